// File: rtl/uart_cmd_dispatch_pkg.sv
// Shared command codes, NAK bytes, timeouts and state encoding for the ECT host command path.
package ect_cmd_pkg;
  localparam logic [7:0]  HDR          = 8'hAA;
  localparam logic [7:0]  REQ_DMD_CH1  = 8'h02;
  localparam logic [7:0]  REQ_DMD_CH2  = 8'h03;
  localparam logic [7:0]  CMD_MIN      = REQ_DMD_CH1;
  localparam logic [7:0]  CMD_MAX      = REQ_DMD_CH2;
  localparam logic [7:0]  NAK_FRAME    = 8'hEE;
  localparam logic [7:0]  NAK_TMO      = 8'hEF;
  localparam logic [15:0] GAP_TMO_DEF  = 16'd50000;
  localparam logic [31:0] EXEC_TMO_DEF = 32'd10000000;

  typedef enum logic [2:0] {
    ST_HUNT, ST_GET_CMD, ST_GET_CHK, ST_CHECK, ST_EXEC, ST_RELEASE, ST_NAK_WAIT
  } state_t;

  function automatic logic cmdOk(input logic [7:0] cmd, input logic [7:0] chk);
    return (chk == ~cmd) && (cmd >= CMD_MIN) && (cmd <= CMD_MAX);
  endfunction
endpackage

// File: rtl/uart_cmd_dispatch_if.sv
// Host byte stream, worker SysState/Enable/Done handshake and shared UART transmit bus.
// master = dispatcher side, slave = UART receiver/transmitter and workers.
interface uart_cmd_dispatch_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic [7:0] SysState;
  logic       Enable;
  logic       Done;
  logic       BusOwned;
  logic       UARTAvl;
  logic [7:0] UARTSend;
  logic       UARTDatLock;
  logic [7:0] ErrCnt;

  modport master (input RxData, RxValid, Done, BusOwned, UARTAvl,
                  output SysState, Enable, UARTSend, UARTDatLock, ErrCnt);
  modport slave  (output RxData, RxValid, Done, BusOwned, UARTAvl,
                  input SysState, Enable, UARTSend, UARTDatLock, ErrCnt);
endinterface

// File: rtl/uart_cmd_dispatch_frame_rx.sv
// HDR,CMD,CHK frame hunter with inter-byte gap timeout; FrameValid is combinational on the CHK byte.
// No backpressure: bytes arriving while RxEn is low are dropped.
module cmd_frame_rx #(
  parameter logic [15:0] GAP_TMO = ect_cmd_pkg::GAP_TMO_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEn,
  input  logic [7:0] RxData,
  input  logic       RxValid,
  output logic       FrameValid,
  output logic [7:0] Cmd,
  output logic [7:0] Chk
);
  import ect_cmd_pkg::*;

  state_t      state, stateNxt;
  logic [7:0]  cmdQ, cmdNxt;
  logic [15:0] gapTimer, gapNxt;
  logic        rxByte;

  assign rxByte = RxValid && RxEn;
  assign Cmd    = cmdQ;
  assign Chk    = RxData;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= ST_HUNT;
      cmdQ     <= '0;
      gapTimer <= '0;
    end else begin
      state    <= stateNxt;
      cmdQ     <= cmdNxt;
      gapTimer <= gapNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    cmdNxt     = cmdQ;
    gapNxt     = gapTimer;
    FrameValid = 1'b0;
    case (state)
      ST_HUNT: begin
        gapNxt = '0;
        if (rxByte && RxData == HDR) stateNxt = ST_GET_CMD;
      end
      // A HDR value here is plain data; no resync mid-frame.
      ST_GET_CMD, ST_GET_CHK: begin
        if (rxByte) begin
          gapNxt = '0;
          if (state == ST_GET_CMD) begin
            cmdNxt   = RxData;
            stateNxt = ST_GET_CHK;
          end else begin
            FrameValid = 1'b1;
            stateNxt   = ST_HUNT;
          end
        end else if (gapTimer == GAP_TMO - 16'd1) begin
          gapNxt   = '0;
          stateNxt = ST_HUNT;
        end else begin
          gapNxt = gapTimer + 16'd1;
        end
      end
      default: stateNxt = ST_HUNT;
    endcase
  end
endmodule

// File: rtl/uart_cmd_dispatch.sv
// Validates host frames, holds SysState/Enable until worker Done, NAKs bad frames and worker timeouts.
// SysState/Enable valid 2 cycles after the CHK byte; a NAK waits for a free UART bus, incoming bytes dropped meanwhile.
module uart_cmd_dispatch #(
  parameter logic [15:0] GAP_TMO  = ect_cmd_pkg::GAP_TMO_DEF,
  parameter logic [31:0] EXEC_TMO = ect_cmd_pkg::EXEC_TMO_DEF
) (
  input logic                 Clk,
  input logic                 Rst,
  uart_cmd_dispatch_if.master Bus
);
  import ect_cmd_pkg::*;

  state_t      state, stateNxt;
  logic [7:0]  cmdQ, cmdNxt, chkQ, chkNxt;
  logic [7:0]  sysState, sysNxt, uartSend, sendNxt, errCnt, errNxt;
  logic        enable, enNxt, datLock;
  logic [31:0] execTimer, execNxt;
  logic        rxEn, frameValid;
  logic [7:0]  rxCmd, rxChk;

  // ST_HUNT here stands for "receiver owns the line"; its sub-states live in cmd_frame_rx.
  assign rxEn = (state == ST_HUNT);

  cmd_frame_rx #(.GAP_TMO(GAP_TMO)) uFrameRx (
    .Clk(Clk), .Rst(Rst), .RxEn(rxEn), .RxData(Bus.RxData), .RxValid(Bus.RxValid),
    .FrameValid(frameValid), .Cmd(rxCmd), .Chk(rxChk)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= ST_HUNT;
      cmdQ      <= '0;
      chkQ      <= '0;
      sysState  <= '0;
      enable    <= 1'b0;
      uartSend  <= '0;
      errCnt    <= '0;
      execTimer <= '0;
    end else begin
      state     <= stateNxt;
      cmdQ      <= cmdNxt;
      chkQ      <= chkNxt;
      sysState  <= sysNxt;
      enable    <= enNxt;
      uartSend  <= sendNxt;
      errCnt    <= errNxt;
      execTimer <= execNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cmdNxt   = cmdQ;
    chkNxt   = chkQ;
    sysNxt   = sysState;
    enNxt    = enable;
    sendNxt  = uartSend;
    errNxt   = errCnt;
    execNxt  = execTimer;
    datLock  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (frameValid) begin
          cmdNxt   = rxCmd;
          chkNxt   = rxChk;
          stateNxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cmdOk(cmdQ, chkQ)) begin
          sysNxt   = cmdQ;
          enNxt    = 1'b1;
          execNxt  = '0;
          stateNxt = ST_EXEC;
        end else begin
          sendNxt  = NAK_FRAME;
          stateNxt = ST_NAK_WAIT;
        end
      end
      // Done is checked first so it wins over a timeout landing on the same cycle.
      ST_EXEC: begin
        if (Bus.Done) begin
          sysNxt   = '0;
          enNxt    = 1'b0;
          stateNxt = ST_RELEASE;
        end else if (execTimer == EXEC_TMO - 32'd1) begin
          sysNxt   = '0;
          enNxt    = 1'b0;
          sendNxt  = NAK_TMO;
          stateNxt = ST_NAK_WAIT;
        end else begin
          execNxt = execTimer + 32'd1;
        end
      end
      ST_RELEASE: begin
        if (!Bus.Done) stateNxt = ST_HUNT;
      end
      // Strobe is combinational so it can never overlap a cycle where BusOwned is high.
      ST_NAK_WAIT: begin
        if (!Bus.BusOwned && Bus.UARTAvl) begin
          datLock  = Rst;
          stateNxt = ST_HUNT;
          if (errCnt != 8'hFF) errNxt = errCnt + 8'd1;
        end
      end
      default: stateNxt = ST_HUNT;
    endcase
  end

  assign Bus.SysState    = sysState;
  assign Bus.Enable      = enable;
  assign Bus.UARTSend    = uartSend;
  assign Bus.UARTDatLock = datLock;
  assign Bus.ErrCnt      = errCnt;
endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Bench for uart_cmd_dispatch: table vectors, random frames against a transaction-level model, reset corner cases.
module tb_uart_cmd_dispatch;
  localparam int GAP = 50;
  localparam int EXT = 100;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         gap, doneDly, busHold, avlHold;
    bit         intrude;
    int         expEn, expEnStart, expStrobes;
    logic [7:0] expByte;
    int         expStrobeAt;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;
  int   expErr = 0;

  uart_cmd_dispatch_if busIf();

  uart_cmd_dispatch #(.GAP_TMO(16'd50), .EXEC_TMO(32'd100)) dut (
    .Clk(Clk), .Rst(Rst), .Bus(busIf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Transaction-level expectation: bytes at cycles 0, 1+gap, 2+gap; Enable two cycles after the
  // last byte; worker Done after doneDly Enable cycles; NAK once bus free and transmitter ready.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   t2, nakAt;
    r = v;
    t2 = 2 + v.gap;
    r.expEn = 0; r.expEnStart = -1; r.expStrobes = 0; r.expByte = 8'h00; r.expStrobeAt = -1;
    if (v.gap >= GAP || v.b0 != 8'hAA) return r;
    if (v.b2 == ~v.b1 && v.b1 >= 8'h02 && v.b1 <= 8'h03) begin
      r.expEnStart = t2 + 2;
      if (v.doneDly <= EXT) begin
        r.expEn = v.doneDly;
        return r;
      end
      r.expEn   = EXT;
      r.expByte = 8'hEF;
      nakAt     = t2 + 2 + EXT;
    end else begin
      r.expByte = 8'hEE;
      nakAt     = t2 + 2;
    end
    if (v.busHold > nakAt) nakAt = v.busHold;
    if (v.avlHold > nakAt) nakAt = v.avlHold;
    r.expStrobes  = 1;
    r.expStrobeAt = nakAt;
    return r;
  endfunction

  // Called just after a rising edge; runs 'cycles' cycles playing host, UART bus and worker.
  task automatic runVec(input vec_t v, input int cycles, input string tag);
    int enCyc = 0, enStart = -1, rises = 0, strobes = 0, strobeAt = -1, bad = 0, relCnt = 0;
    int t1, t2, k;
    logic [7:0] lastByte = 8'h00, sysSeen = 8'h00;
    bit prevEn = 1'b0;
    t1 = 1 + v.gap;
    t2 = 2 + v.gap;
    for (int c = 0; c < cycles; c++) begin
      busIf.RxValid = 1'b0;
      busIf.RxData  = 8'h00;
      if (c == 0)  begin busIf.RxValid = 1'b1; busIf.RxData = v.b0; end
      if (c == t1) begin busIf.RxValid = 1'b1; busIf.RxData = v.b1; end
      if (c == t2) begin busIf.RxValid = 1'b1; busIf.RxData = v.b2; end
      if (v.intrude && enStart >= 0 && c >= enStart + 3 && c < enStart + 6) begin
        k = c - enStart - 3;
        busIf.RxValid = 1'b1;
        busIf.RxData  = (k == 0) ? 8'hAA : (k == 1) ? 8'h03 : 8'hFC;
      end
      busIf.BusOwned = (c < v.busHold);
      busIf.UARTAvl  = (c >= v.avlHold);
      @(negedge Clk);
      if (busIf.Enable) begin
        if (!prevEn) begin
          rises++;
          if (enStart < 0) enStart = c;
          sysSeen = busIf.SysState;
        end
        enCyc++;
        if (busIf.SysState != sysSeen) bad++;
      end else if (busIf.SysState != 8'h00) begin
        bad++;
      end
      if (busIf.UARTDatLock) begin
        strobes++;
        strobeAt = c;
        lastByte = busIf.UARTSend;
        if (busIf.BusOwned) bad++;
      end
      prevEn = busIf.Enable;
      if (busIf.Enable && enCyc >= v.doneDly) busIf.Done = 1'b1;
      else if (!busIf.Enable && busIf.Done) begin
        relCnt++;
        if (relCnt >= 2) begin busIf.Done = 1'b0; relCnt = 0; end
      end
      @(posedge Clk); #1;
    end
    busIf.Done = 1'b0;
    expErr = (expErr + v.expStrobes > 255) ? 255 : expErr + v.expStrobes;
    check({tag, ".enCycles"}, enCyc, v.expEn);
    check({tag, ".enStart"}, enStart, v.expEnStart);
    check({tag, ".enRises"}, rises, (v.expEn > 0) ? 1 : 0);
    if (v.expEn > 0) check({tag, ".sysState"}, int'(sysSeen), int'(v.b1));
    check({tag, ".strobes"}, strobes, v.expStrobes);
    check({tag, ".strobeAt"}, strobeAt, v.expStrobeAt);
    if (v.expStrobes > 0) check({tag, ".nakByte"}, int'(lastByte), int'(v.expByte));
    check({tag, ".protocol"}, bad, 0);
    check({tag, ".errCnt"}, int'(busIf.ErrCnt), expErr);
  endtask

  task automatic sendByte(input logic [7:0] b);
    busIf.RxValid = 1'b1;
    busIf.RxData  = b;
    @(posedge Clk); #1;
    busIf.RxValid = 1'b0;
  endtask

  initial begin
    vec_t tbl [14];
    vec_t v;
    int   bad;

    tbl[0]  = '{8'hAA, 8'h02, 8'hFD,  0,   20,   0,  0, 1'b0,  20,  4, 0, 8'h00,  -1};
    tbl[1]  = '{8'hAA, 8'h03, 8'h00,  0,   20,   0,  0, 1'b0,   0, -1, 1, 8'hEE,   4};
    tbl[2]  = '{8'hAA, 8'h05, 8'hFA,  0,   20,  30,  0, 1'b0,   0, -1, 1, 8'hEE,  30};
    tbl[3]  = '{8'hAA, 8'h02, 8'hFD,  0, 1000,   0,  0, 1'b0, 100,  4, 1, 8'hEF, 104};
    tbl[4]  = '{8'hAA, 8'h02, 8'hFD, 60,   20,   0,  0, 1'b0,   0, -1, 0, 8'h00,  -1};
    tbl[5]  = '{8'hAA, 8'h02, 8'hFD, 40,   20,   0,  0, 1'b0,  20, 44, 0, 8'h00,  -1};
    tbl[6]  = '{8'hAA, 8'h03, 8'hFC,  0,  100,   0,  0, 1'b0, 100,  4, 0, 8'h00,  -1};
    tbl[7]  = '{8'hAA, 8'h03, 8'hFC,  0,  101,   0,  0, 1'b0, 100,  4, 1, 8'hEF, 104};
    tbl[8]  = '{8'hAA, 8'h01, 8'hFE,  0,   20,   0,  0, 1'b0,   0, -1, 1, 8'hEE,   4};
    tbl[9]  = '{8'hAA, 8'h02, 8'hFD,  0,   20,   0,  0, 1'b1,  20,  4, 0, 8'h00,  -1};
    tbl[10] = '{8'hAA, 8'hAA, 8'h02,  0,   20,   0,  0, 1'b0,   0, -1, 1, 8'hEE,   4};
    tbl[11] = '{8'hAA, 8'h02, 8'hFD,  0,    1,   0,  0, 1'b0,   1,  4, 0, 8'h00,  -1};
    tbl[12] = '{8'hAA, 8'h02, 8'hFD,  0, 1000, 110,  0, 1'b0, 100,  4, 1, 8'hEF, 110};
    tbl[13] = '{8'hAA, 8'h04, 8'hFB,  0,   20,   0, 15, 1'b0,   0, -1, 1, 8'hEE,  15};

    Rst = 1'b0;
    busIf.RxValid = 1'b0; busIf.RxData = 8'h00; busIf.Done = 1'b0;
    busIf.BusOwned = 1'b0; busIf.UARTAvl = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset.sysState", int'(busIf.SysState), 0);
    check("reset.enable", int'(busIf.Enable), 0);
    check("reset.uartSend", int'(busIf.UARTSend), 0);
    check("reset.datLock", int'(busIf.UARTDatLock), 0);
    check("reset.errCnt", int'(busIf.ErrCnt), 0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    for (int i = 0; i < 14; i++) runVec(tbl[i], 200, $sformatf("tbl%0d", i));

    for (int i = 0; i < 30; i++) begin
      v.b0      = ($urandom_range(0, 7) == 0) ? 8'h11 : 8'hAA;
      v.b1      = 8'($urandom_range(0, 5));
      v.b2      = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : ~v.b1;
      v.gap     = $urandom_range(0, 3);
      v.doneDly = $urandom_range(1, 120);
      v.busHold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 120);
      v.avlHold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      v.intrude = 1'b0;
      runVec(model(v), 200, $sformatf("rnd%0d", i));
    end

    v = '{8'hAA, 8'h05, 8'hFA, 0, 20, 0, 0, 1'b0, 0, -1, 1, 8'hEE, 4};
    for (int i = 0; i < 260; i++) runVec(v, 8, $sformatf("sat%0d", i));
    check("sat.errCnt", int'(busIf.ErrCnt), 255);

    sendByte(8'hAA); sendByte(8'h02); sendByte(8'hFD);
    repeat (10) begin @(posedge Clk); #1; end
    @(negedge Clk);
    check("rst.preEnable", int'(busIf.Enable), 1);
    check("rst.preSysState", int'(busIf.SysState), 2);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("rst.enable", int'(busIf.Enable), 0);
    check("rst.sysState", int'(busIf.SysState), 0);
    check("rst.errCnt", int'(busIf.ErrCnt), 0);
    check("rst.datLock", int'(busIf.UARTDatLock), 0);
    expErr = 0;
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge Clk);
      if (busIf.UARTDatLock || busIf.Enable) bad++;
    end
    check("rst.quiet", bad, 0);
    @(posedge Clk); #1;
    sendByte(8'h11);
    runVec(tbl[0], 200, "postRst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_dispatch.md
Name: uart_cmd_dispatch

Overview:
- Host-side command front end for the ECT controller, and the initiating end of the SysState/Enable/Done handshake that the sampling workers (per-channel ADC demod requesters) respond to.
- Receives framed command bytes from the UART receiver, validates them and drives SysState and Enable to the addressed worker.
- Holds the command until the worker reports Done, then releases it.
- Reports framing or command errors and worker timeouts to the host with a single NAK byte on the shared UART transmit bus.

Parameters:
- HDR, 8'hAA, frame header byte.
- CMD_MIN, 8'h02, lowest legal command code.
- CMD_MAX, 8'h03, highest legal command code.
- NAK_FRAME, 8'hEE, byte sent on a bad checksum or an illegal command.
- NAK_TMO, 8'hEF, byte sent when a worker fails to finish in time.
- GAP_TMO, 16'd50000, maximum clock cycles allowed between bytes of one frame.
- EXEC_TMO, 32'd10000000, maximum clock cycles Enable may stay high waiting for Done.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-low; sampled only on the rising edge of Clk.
- RxData  in  8  byte from the UART receiver.
- RxValid  in  1  one-cycle strobe: RxData is valid.
- SysState  out  8  current command code; 8'h00 when idle.
- Enable  out  1  command active.
- Done  in  1  OR of the worker done flags.
- BusOwned  in  1  OR of the worker ApplyUART lines; the transmit bus is taken.
- UARTAvl  in  1  UART transmitter ready.
- UARTSend  out  8  byte to transmit.
- UARTDatLock  out  1  one-cycle latch strobe for UARTSend.
- ErrCnt  out  8  saturating count of NAKs sent.

Behaviour:
- Reset: Rst low at a clock edge sets state HUNT, SysState=0, Enable=0, UARTSend=0, UARTDatLock=0, ErrCnt=0, all timers=0.
  - Reset mid-frame or mid-EXEC aborts immediately with no NAK.
- Frame format: HDR, CMD, CHK, where CHK must equal ~CMD.
- HUNT:
  - RxValid with RxData==HDR -> GET_CMD.
  - Any other byte is ignored.
- GET_CMD: RxValid -> latch CMD -> GET_CHK.
- GET_CHK: RxValid -> CHECK.
- Gap timer:
  - Cleared on every RxValid; counts only in GET_CMD and GET_CHK.
  - Reaching GAP_TMO -> HUNT silently.
- CHECK (one cycle): (CHK==~CMD) and CMD_MIN<=CMD<=CMD_MAX -> EXEC; otherwise load NAK_FRAME -> NAK_WAIT.
- EXEC:
  - SysState=CMD and Enable=1, both registered and visible the cycle after CHECK.
  - Exec timer counts from 0.
  - Done=1 -> RELEASE.
  - Timer reaching EXEC_TMO -> load NAK_TMO -> NAK_WAIT.
  - Done and timeout in the same cycle: Done wins.
  - Enable and SysState are held constant for the whole of EXEC.
- RELEASE:
  - Enable=0 and SysState=0 in the first RELEASE cycle.
  - Stay in RELEASE until Done==0, so the worker clears its flags, then go to HUNT.
  - Minimum one cycle with Enable low between commands.
- NAK_WAIT:
  - Enable=0, SysState=0.
  - Wait for BusOwned==0 && UARTAvl==1, then UARTDatLock=1 for exactly one cycle, ErrCnt+1 (saturates at 255), -> HUNT.
  - UARTSend is stable from entry to NAK_WAIT through the strobe cycle.
- RxValid outside HUNT/GET_CMD/GET_CHK (CHECK, EXEC, RELEASE, NAK_WAIT): the byte is dropped and no frame state is kept.
- A HDR byte received in GET_CMD or GET_CHK is treated as data, with no resync.
- UARTDatLock is never asserted while BusOwned=1.

Decomposition:
- Shared package ect_cmd_pkg holds: command codes (REQ_DMD_CH1=8'h02, REQ_DMD_CH2=8'h03), HDR, NAK codes, and the state encoding.
- Sub-module cmd_frame_rx: HUNT/GET_CMD/GET_CHK plus the gap timer. Outputs a one-cycle FrameValid with Cmd/Chk.
- uart_cmd_dispatch owns CHECK/EXEC/RELEASE/NAK_WAIT.

Test Plan:
- Bytes AA,02,FD with Done raised 20 cycles after Enable -> SysState=02 and Enable=1 the cycle after CHECK. Both return to 0 the cycle after Done. HUNT is re-entered once Done drops. No UARTDatLock.
- Bytes AA,03,00 (bad checksum) with UARTAvl=1 and BusOwned=0 -> Enable never rises. UARTSend=EE with one UARTDatLock pulse. ErrCnt=1.
- Bytes AA,05,FA (illegal command) while BusOwned=1 for 30 cycles -> no strobe while BusOwned=1. A single EE strobe after BusOwned falls.
- AA,02,FD with Done held low and EXEC_TMO=100 -> Enable high for exactly 100 cycles, then EF sent and Enable=0.
- AA, then 60 idle cycles with GAP_TMO=50, then 02,FD -> the frame is discarded with no Enable. A following AA,02,FD executes normally.
- Rst low during EXEC -> next cycle Enable=0, SysState=0, no NAK. Bytes 11,AA,02,FD after reset -> the leading 11 is ignored and the command executes.
